// File: rtl/seq_addsub.sv
// Iterative add/subtract: one CHUNK_W slice per clock, LSB first, with Y86-64 flags.
// Optional saturation on signed overflow when SEQ_ADDSUB_SAT_EN is defined.
//
//   state | meaning
//   IDLE  | waiting for start
//   RUN   | one slice per edge, N edges
//   DONE  | one-cycle done pulse; start accepted here for back-to-back ops
module seq_addsub #(
  parameter int DATA_W  = 64,
  parameter int CHUNK_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              op,
  input  logic [DATA_W-1:0] A,
  input  logic [DATA_W-1:0] B,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] Result,
  output logic              Cout,
  output logic              ZF,
  output logic              SF,
  output logic              OF
);

  localparam int N     = DATA_W / CHUNK_W;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   opa_q, opa_d;
  logic [DATA_W-1:0]   opb_q, opb_d;
  logic [DATA_W-1:0]   sum_q, sum_d;
  logic                carry_q, carry_d;
  logic                op_q, op_d;
  logic                a_msb_q, a_msb_d;
  logic                b_msb_q, b_msb_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   result_q, result_d;
  logic                cout_q, cout_d;
  logic                zf_q, zf_d;
  logic                sf_q, sf_d;
  logic                of_q, of_d;

  logic [CHUNK_W:0]    slice_sum;
  logic [DATA_W-1:0]   full_sum;
  logic                raw_of;
  logic [DATA_W-1:0]   final_res;

  // Operands shift right each edge, so the active slice is always the low chunk.
  assign slice_sum = {1'b0, opa_q[CHUNK_W-1:0]} + {1'b0, opb_q[CHUNK_W-1:0]}
                   + (CHUNK_W+1)'(carry_q);
  assign full_sum  = DATA_W'({slice_sum[CHUNK_W-1:0], sum_q} >> CHUNK_W);

  assign raw_of = op_q ? ((a_msb_q != b_msb_q) && (full_sum[DATA_W-1] != a_msb_q))
                       : ((a_msb_q == b_msb_q) && (full_sum[DATA_W-1] != a_msb_q));

`ifdef SEQ_ADDSUB_SAT_EN
  assign final_res = !raw_of ? full_sum
                   : a_msb_q ? {1'b1, {(DATA_W-1){1'b0}}}
                             : {1'b0, {(DATA_W-1){1'b1}}};
`else
  assign final_res = full_sum;
`endif

  always_comb begin
    state_d  = state_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    sum_d    = sum_q;
    carry_d  = carry_q;
    op_d     = op_q;
    a_msb_d  = a_msb_q;
    b_msb_d  = b_msb_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    cout_d   = cout_q;
    zf_d     = zf_q;
    sf_d     = sf_q;
    of_d     = of_q;
    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (start) begin
          opa_d   = A;
          opb_d   = op ? ~B : B;
          carry_d = op;
          op_d    = op;
          a_msb_d = A[DATA_W-1];
          b_msb_d = B[DATA_W-1];
          sum_d   = '0;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        opa_d   = opa_q >> CHUNK_W;
        opb_d   = opb_q >> CHUNK_W;
        carry_d = slice_sum[CHUNK_W];
        sum_d   = full_sum;
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_CNT) begin
          result_d = final_res;
          cout_d   = slice_sum[CHUNK_W];
          zf_d     = (final_res == '0);
          sf_d     = final_res[DATA_W-1];
          of_d     = raw_of;
          state_d  = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      opa_q    <= '0;
      opb_q    <= '0;
      sum_q    <= '0;
      carry_q  <= 1'b0;
      op_q     <= 1'b0;
      a_msb_q  <= 1'b0;
      b_msb_q  <= 1'b0;
      cnt_q    <= '0;
      result_q <= '0;
      cout_q   <= 1'b0;
      zf_q     <= 1'b0;
      sf_q     <= 1'b0;
      of_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      sum_q    <= sum_d;
      carry_q  <= carry_d;
      op_q     <= op_d;
      a_msb_q  <= a_msb_d;
      b_msb_q  <= b_msb_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      cout_q   <= cout_d;
      zf_q     <= zf_d;
      sf_q     <= sf_d;
      of_q     <= of_d;
    end
  end

  assign busy   = (state_q == RUN);
  assign done   = (state_q == DONE);
  assign Result = result_q;
  assign Cout   = cout_q;
  assign ZF     = zf_q;
  assign SF     = sf_q;
  assign OF     = of_q;

endmodule

// File: tb/tb_seq_addsub.sv
// Scoreboard bench for seq_addsub: directed vectors push expectations, a monitor checks on done.
// Expectations follow SEQ_ADDSUB_SAT_EN when it is defined for the build.
module tb_seq_addsub;

  localparam int N = 4;

  logic        clk;
  logic        rst;
  logic        start;
  logic        op;
  logic [63:0] A;
  logic [63:0] B;
  logic        busy;
  logic        done;
  logic [63:0] Result;
  logic        Cout;
  logic        ZF;
  logic        SF;
  logic        OF;

  seq_addsub dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .op    (op),
    .A     (A),
    .B     (B),
    .busy  (busy),
    .done  (done),
    .Result(Result),
    .Cout  (Cout),
    .ZF    (ZF),
    .SF    (SF),
    .OF    (OF)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] r;
    logic        c;
    logic        z;
    logic        s;
    logic        o;
    int          due;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   cyc    = 0;
  int   n_cmp  = 0;
  int   n_err  = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && done === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_done: got done=1 expected no pending op (cycle %0d)", cyc);
      end else begin
        mon_e = exp_q.pop_front();
        chk("result",  Result, mon_e.r);
        chk("cout",    64'(Cout), 64'(mon_e.c));
        chk("zf",      64'(ZF),   64'(mon_e.z));
        chk("sf",      64'(SF),   64'(mon_e.s));
        chk("of",      64'(OF),   64'(mon_e.o));
        chk("latency", 64'(cyc),  64'(mon_e.due));
        chk("busy_at_done", 64'(busy), 64'd0);
      end
    end
  end

  // Drive start at the current negedge, record expectation, drop start one cycle later.
  task automatic issue_now(input logic o_i, input logic [63:0] a_i, input logic [63:0] b_i,
                           input logic [63:0] r, input logic c, input logic z,
                           input logic s, input logic o);
    exp_t e;
    start = 1'b1;
    op    = o_i;
    A     = a_i;
    B     = b_i;
    e.r = r; e.c = c; e.z = z; e.s = s; e.o = o;
    e.due = cyc + 1 + N;
    exp_q.push_back(e);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic issue(input logic o_i, input logic [63:0] a_i, input logic [63:0] b_i,
                       input logic [63:0] r, input logic c, input logic z,
                       input logic s, input logic o);
    @(negedge clk);
    issue_now(o_i, a_i, b_i, r, c, z, s, o);
  endtask

  task automatic drain(input int max);
    int t = 0;
    while (exp_q.size() != 0 && t < max) begin
      @(negedge clk);
      t++;
    end
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"},   64'(busy), 64'd0);
    chk({tag, "_done"},   64'(done), 64'd0);
    chk({tag, "_result"}, Result,    64'd0);
    chk({tag, "_cout"},   64'(Cout), 64'd0);
    chk({tag, "_zf"},     64'(ZF),   64'd0);
    chk({tag, "_sf"},     64'(SF),   64'd0);
    chk({tag, "_of"},     64'(OF),   64'd0);
  endtask

  initial begin
    int t;
    rst   = 1'b1;
    start = 1'b0;
    op    = 1'b0;
    A     = '0;
    B     = '0;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rst = 1'b0;
    @(negedge clk);

    // 11 + 4, busy for exactly the four RUN cycles
    issue(1'b0, 64'd11, 64'd4, 64'd15, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("busy_run0", 64'(busy), 64'd1);
    for (int i = 1; i < N; i++) begin
      @(negedge clk);
      chk("busy_run", 64'(busy), 64'd1);
    end
    drain(20);

`ifdef SEQ_ADDSUB_SAT_EN
    issue(1'b0, 64'd1, 64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 1'b0, 1'b1);
    drain(20);
    issue(1'b1, 64'h8000_0000_0000_0000, 64'd1, 64'h8000_0000_0000_0000, 1'b1, 1'b0, 1'b1, 1'b1);
    drain(20);
`else
    issue(1'b0, 64'd1, 64'h7FFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 1'b0, 1'b0, 1'b1, 1'b1);
    drain(20);
    issue(1'b1, 64'h8000_0000_0000_0000, 64'd1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b0, 1'b1);
    drain(20);
`endif

    issue(1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 1'b1, 1'b1, 1'b0, 1'b0);
    drain(20);
    issue(1'b1, 64'd5, 64'd5, 64'd0, 1'b1, 1'b1, 1'b0, 1'b0);
    drain(20);
    issue(1'b1, 64'd4, 64'd11, 64'hFFFF_FFFF_FFFF_FFF9, 1'b0, 1'b0, 1'b1, 1'b0);
    drain(20);

    // start pulsed during RUN must be ignored
    issue(1'b0, 64'd27, 64'd19, 64'd46, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    start = 1'b1;
    A     = 64'd1;
    B     = 64'd1;
    @(negedge clk);
    start = 1'b0;
    drain(20);
    repeat (6) @(negedge clk);

    // back-to-back: start present in the DONE cycle
    issue(1'b1, 64'd100, 64'd1, 64'd99, 1'b1, 1'b0, 1'b0, 1'b0);
    t = 0;
    while (done !== 1'b1 && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (done !== 1'b1) begin
      n_cmp++;
      n_err++;
      $display("FAIL b2b_wait: got done=0 expected done=1 within 20 cycles");
    end
    issue_now(1'b0, 64'd3, 64'd4, 64'd7, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 1; i < N; i++) begin
      chk("result_hold", Result, 64'd99);
      @(negedge clk);
    end
    drain(20);

    // reset two RUN edges into an operation aborts it
    issue(1'b0, 64'h5555_5555_5555_5555, 64'h1111_1111_1111_1111,
          64'h6666_6666_6666_6666, 1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    exp_q.delete();
    #1 chk_all_zero("abort");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    issue(1'b0, 64'h5555_5555_5555_5555, 64'h1111_1111_1111_1111,
          64'h6666_6666_6666_6666, 1'b0, 1'b0, 1'b0, 1'b0);
    drain(20);
    repeat (4) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
